key_filter: RTL and testbench

- Debounces one asynchronous mechanical key input and produces a clean, synchronous, level-stable key state.
- Also produces single-cycle press and release strobes.
- Sits between a board pin (button) and control logic such as LED sequencers or counters, which consume key_out or the strobes.
- A level change is accepted only after the synchronized input has held the new level for N consecutive clock cycles.

---
 rtl/key_filter.sv | 104 ++++++++++
 tb/tb_key_filter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/key_filter.sv
// Debounces one asynchronous key input: two-flop synchronizer feeding a
// four-state filter that accepts a new level only after it has held steadily.
module key_filter #(
  parameter int N     = 10,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_out,
  output logic key_press,
  output logic key_release
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILT,
    PRESSED,
    REL_FILT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N);

  state_t           state_reg;
  logic             s1_reg;
  logic             s2_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg      <= 1'b0;
      s2_reg      <= 1'b0;
      cnt_reg     <= '0;
      state_reg   <= IDLE;
      key_out     <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      s1_reg      <= key_in;
      s2_reg      <= s1_reg;
      key_press   <= 1'b0;
      key_release <= 1'b0;

      case (state_reg)
        IDLE: begin
          key_out <= 1'b0;
          if (s2_reg) begin
            state_reg <= PRESS_FILT;
            cnt_reg   <= CNT_ONE;
          end else begin
            cnt_reg <= '0;
          end
        end

        PRESS_FILT: begin
          // Any return to the accepted level discards the partial count.
          if (!s2_reg) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
            key_out   <= 1'b1;
            key_press <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        PRESSED: begin
          key_out <= 1'b1;
          if (!s2_reg) begin
            state_reg <= REL_FILT;
            cnt_reg   <= CNT_ONE;
          end else begin
            cnt_reg <= '0;
          end
        end

        REL_FILT: begin
          if (s2_reg) begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            key_out     <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          key_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter: a N=10 and a N=1 instance driven by a table
// of input segments with hand-computed change points, plus a mid-filter reset.
module tb_key_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, key0, out0, press0, rel0;
  logic rst1, key1, out1, press1, rel1;

  key_filter #(.N(10)) dut10 (
    .clk(clk), .reset(rst0), .key_in(key0),
    .key_out(out0), .key_press(press0), .key_release(rel0)
  );

  key_filter #(.N(1)) dut1 (
    .clk(clk), .reset(rst1), .key_in(key1),
    .key_out(out1), .key_press(press1), .key_release(rel1)
  );

  // One segment: hold rst/kin on one DUT for len edges. key_out starts at
  // lvl and flips after edge index chg (-1 = never), with the matching strobe
  // only on that edge.
  typedef struct {
    bit dut;
    bit rst;
    bit kin;
    int len;
    bit lvl;
    int chg;
  } seg_t;

  seg_t segs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input bit d, input bit r, input bit k, input int len,
                     input bit lvl, input int chg);
    seg_t s;
    s.dut = d; s.rst = r; s.kin = k; s.len = len; s.lvl = lvl; s.chg = chg;
    segs.push_back(s);
  endtask

  task automatic check3(input string name, input logic [2:0] act,
                        input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got out/press/rel=%b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    logic [2:0] act, exp;
    bit         eo;
    int         first_press, presses;

    rst0 = 1'b1; key0 = 1'b0;
    rst1 = 1'b1; key1 = 1'b0;

    // N=10 instance
    add(0, 1, 0, 50, 0, -1);   // long reset, key released
    add(0, 0, 0,  5, 0, -1);   // deassert: nothing happens
    add(0, 0, 1,  3, 0, -1);   // short press rejected
    add(0, 0, 0,  6, 0, -1);
    add(0, 0, 1,  3, 0, -1);   // bounce train, count restarts each time
    add(0, 0, 0,  3, 0, -1);
    add(0, 0, 1,  7, 0, -1);
    add(0, 0, 0,  3, 0, -1);
    add(0, 0, 0,  4, 0, -1);
    add(0, 0, 1, 20, 0, 12);   // held press accepted after N+2 edges
    add(0, 0, 0,  6, 1, -1);   // release filtering starts ...
    add(0, 0, 1,  5, 1, -1);   // ... 5-cycle glitch restarts it
    add(0, 0, 0, 20, 1, 12);   // clean release
    add(0, 0, 1, 15, 0, 12);   // press again
    add(0, 1, 1,  3, 0, -1);   // reset while pressed: drop, no release
    add(0, 0, 1, 16, 0, 12);   // held key re-filtered after reset
    add(0, 0, 0, 16, 1, 12);
    // N=1 instance
    add(1, 1, 0,  3, 0, -1);
    add(1, 0, 0,  4, 0, -1);
    add(1, 0, 1,  1, 0, -1);   // single-cycle bounce rejected
    add(1, 0, 0,  4, 0, -1);
    add(1, 0, 1,  6, 0,  3);
    add(1, 0, 0,  1, 1, -1);   // single-cycle release glitch rejected
    add(1, 0, 1,  4, 1, -1);
    add(1, 0, 0,  6, 1,  3);

    @(negedge clk);
    for (int s = 0; s < segs.size(); s++) begin
      int seg_err;
      seg_err = errors;
      if (segs[s].dut) begin rst1 = segs[s].rst; key1 = segs[s].kin; end
      else             begin rst0 = segs[s].rst; key0 = segs[s].kin; end
      for (int i = 0; i < segs[s].len; i++) begin
        @(posedge clk);
        #1;
        act = segs[s].dut ? {out1, press1, rel1} : {out0, press0, rel0};
        eo  = (segs[s].chg >= 0 && i >= segs[s].chg) ? ~segs[s].lvl : segs[s].lvl;
        exp = {eo, (i == segs[s].chg) && !segs[s].lvl, (i == segs[s].chg) && segs[s].lvl};
        check3($sformatf("seg%0d_cyc%0d", s, i), act, exp);
      end
      $display("seg %0d: dut N=%0d rst=%0b key_in=%0b len=%0d change_at=%0d errors_in_seg=%0d",
               s, segs[s].dut ? 1 : 10, segs[s].rst, segs[s].kin, segs[s].len,
               segs[s].chg, errors - seg_err);
    end

    // Reset in the middle of press filtering with the key still held.
    key0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check3($sformatf("midfilt_cyc%0d", i), {out0, press0, rel0}, 3'b000);
    end
    rst0 = 1'b1;
    @(posedge clk); #1;
    check3("midfilt_reset", {out0, press0, rel0}, 3'b000);
    rst0 = 1'b0;
    first_press = -1;
    presses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (press0) begin
        presses++;
        if (first_press < 0) first_press = i;
      end
      if (rel0) check3("midfilt_no_release", {out0, press0, rel0}, {out0, press0, 1'b0});
    end
    check_int("midfilt_press_edge", first_press, 12);
    check_int("midfilt_press_count", presses, 1);
    check3("midfilt_final", {out0, press0, rel0}, 3'b100);
    $display("midfilt: first_press=%0d presses=%0d", first_press, presses);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
